fetch_stage: RTL

- Upstream neighbour of the control unit in the pipelined MIPS core.
- Holds the program counter and drives the instruction-memory address.
- Registers the fetched word into an IF/ID pipeline register with stall and flush. Exposes OP/Funct to Control.
- Consumes Control's J, Jr, BranchEQ and BranchNE outputs, plus the ID-stage Zero, to select the next PC.

---
 rtl/fetch_stage_pkg.sv | 20 ++
 rtl/fetch_stage_pipe_reg.sv | 29 ++
 rtl/fetch_stage.sv | 99 +++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared constants for the MIPS fetch stage.
// Opcodes, functs and reset/flush words.
package fetch_stage_pkg;
  localparam logic [5:0] OP_R_TYPE = 6'h00;
  localparam logic [5:0] OP_J = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;
  localparam logic [5:0] FUNCT_JR = 6'h08;

  localparam logic [31:0] PC_RESET_DEF = 32'h0040_0000;
  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    SEL_PC4,
    SEL_BR,
    SEL_J,
    SEL_JR
  } pc_sel_e;
endpackage

// File: rtl/fetch_stage_pipe_reg.sv
// Generic pipeline register with sync reset,
// enable and a clear that wins over enable.
module pipe_reg #(
  parameter int W = 32,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] q_d;
  logic [W-1:0] q_q;

  always_comb begin
    q_d = q_q;
    if (clr) q_d = RST_VAL;
    else if (en) q_d = d;
  end

  always_ff @(posedge clk) begin
    if (reset) q_q <= RST_VAL;
    else q_q <= q_d;
  end

  assign q = q_q;
endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, next-PC select and
// the IF/ID pipeline register with stall/flush.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] PC_RESET = PC_RESET_DEF,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD = NOP_WORD_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] Instruction,
  input  logic                  Stall,
  input  logic                  J,
  input  logic                  Jr,
  input  logic                  BranchEQ,
  input  logic                  BranchNE,
  input  logic                  Zero,
  input  logic [DATA_WIDTH-1:0] JrAddr,
  output logic [DATA_WIDTH-1:0] PC,
  output logic [DATA_WIDTH-1:0] IFID_Instruction,
  output logic [DATA_WIDTH-1:0] IFID_PC4,
  output logic                  IFID_Valid,
  output logic [5:0]            OP,
  output logic [5:0]            Funct,
  output logic                  Redirect,
  output logic                  AddrError
);
  localparam int DW = DATA_WIDTH;

  logic [DW-1:0] pc_q, pc_d, pc4;
  logic [DW-1:0] imm_ext, br_tgt, j_tgt, jr_tgt;
  logic [DW-1:0] ifid_instr_q, ifid_pc4_q;
  logic          ifid_valid_q;
  logic [DW:0]   ifid_iv_d, ifid_iv_q;
  logic          br_hit, taken;
  logic          aerr_d, aerr_q;
  pc_sel_e       sel;

  always_comb begin
    pc4 = pc_q + DW'(4);
    imm_ext = {{(DW-16){ifid_instr_q[15]}},
               ifid_instr_q[15:0]};
    br_tgt = ifid_pc4_q + (imm_ext << 2);
    j_tgt = {ifid_pc4_q[DW-1:DW-4],
             ifid_instr_q[25:0], 2'b00};
    jr_tgt = {JrAddr[DW-1:2], 2'b00};
    br_hit = (BranchEQ & Zero) | (BranchNE & ~Zero);
    // An injected NOP or a stalled cycle never redirects.
    taken = ~Stall & ifid_valid_q & (Jr | J | br_hit);
    aerr_d = taken & Jr & (|JrAddr[1:0]);
    sel = SEL_PC4;
    if (taken) begin
      if (Jr) sel = SEL_JR;
      else if (J) sel = SEL_J;
      else sel = SEL_BR;
    end
    pc_d = pc4;
    unique case (sel)
      SEL_JR:  pc_d = jr_tgt;
      SEL_J:   pc_d = j_tgt;
      SEL_BR:  pc_d = br_tgt;
      default: pc_d = pc4;
    endcase
  end

  assign ifid_iv_d = {Instruction, 1'b1};

  pipe_reg #(.W(DW), .RST_VAL(PC_RESET)) u_pc (
    .clk(clk), .reset(reset), .en(~Stall),
    .clr(1'b0), .d(pc_d), .q(pc_q)
  );

  pipe_reg #(.W(DW + 1), .RST_VAL({NOP_WORD, 1'b0})) u_ifid_iv (
    .clk(clk), .reset(reset), .en(~Stall),
    .clr(taken), .d(ifid_iv_d), .q(ifid_iv_q)
  );

  // PC4 still advances on a flush; only the word is squashed.
  pipe_reg #(.W(DW), .RST_VAL('0)) u_ifid_pc4 (
    .clk(clk), .reset(reset), .en(~Stall),
    .clr(1'b0), .d(pc4), .q(ifid_pc4_q)
  );

  pipe_reg #(.W(1), .RST_VAL(1'b0)) u_aerr (
    .clk(clk), .reset(reset), .en(1'b1),
    .clr(1'b0), .d(aerr_d), .q(aerr_q)
  );

  assign {ifid_instr_q, ifid_valid_q} = ifid_iv_q;
  assign PC = pc_q;
  assign IFID_Instruction = ifid_instr_q;
  assign IFID_PC4 = ifid_pc4_q;
  assign IFID_Valid = ifid_valid_q;
  assign OP = ifid_instr_q[31:26];
  assign Funct = ifid_instr_q[5:0];
  assign Redirect = taken;
  assign AddrError = aerr_q;
endmodule
